// File: rtl/botones_pkg.sv
// ---------------------------------------------------------------------------
// botones_pkg
//   Shared definitions for the push-button conditioning path:
//     - estado_t : per-channel FSM states (IDLE / HOLD / REPEAT)
//     - default timing constants for a 100 MHz system clock
//     - ancho()  : counter/timer width helper
// ---------------------------------------------------------------------------
package botones_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } estado_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 2_000_000;   // 20 ms
    localparam int unsigned REPEAT_DELAY_DEF    = 50_000_000;  // 500 ms
    localparam int unsigned REPEAT_PERIOD_DEF   = 20_000_000;  // 200 ms

    // Bits needed to hold 0 .. v-1, never less than 1.
    function automatic int unsigned ancho(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/canal_boton.sv
// ---------------------------------------------------------------------------
// canal_boton
//   One button channel: two-flop synchronizer, debounce filter and the
//   press FSM that produces a raw (unmasked) one-cycle command request.
//   Optional hold-to-repeat is built only when AUTO_REPEAT_EN is defined;
//   otherwise the FSM is IDLE/HOLD and emits one request per press.
//
//   Ports:
//     clk      system clock
//     reset    synchronous, active-low reset
//     btn      raw asynchronous bouncing button (active-high)
//     pulso    combinational request, valid for one cycle
//     estable  debounced button level
// ---------------------------------------------------------------------------
module canal_boton
    import botones_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulso,
    output logic estable
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("canal_boton: timing parameters must be >= 2");
    end

    localparam int unsigned DEB_W = ancho(DEBOUNCE_CYCLES);

    logic             sync_1;
    logic             sync_2;
    logic [DEB_W-1:0] cnt_deb;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_deb <= '0;
            estable <= 1'b0;
        end else if (sync_2 == estable) begin
            cnt_deb <= '0;
        end else if (cnt_deb == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            estable <= sync_2;
            cnt_deb <= '0;
        end else begin
            cnt_deb <= cnt_deb + 1'b1;
        end
    end

    estado_t estado;
    estado_t estado_sig;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W   = ancho(TMR_MAX);

    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_sig;

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado <= IDLE;
            timer  <= '0;
        end else begin
            estado <= estado_sig;
            timer  <= timer_sig;
        end
    end

    // Release takes priority over an expiring timer so no pulse is
    // produced on the cycle the button is seen released.
    always_comb begin
        estado_sig = estado;
        timer_sig  = timer;
        unique case (estado)
            IDLE: begin
                if (estable) begin
                    estado_sig = HOLD;
                    timer_sig  = TMR_W'(REPEAT_DELAY - 1);
                end
            end
            HOLD, REPEAT: begin
                if (!estable) begin
                    estado_sig = IDLE;
                    timer_sig  = '0;
                end else if (timer == '0) begin
                    estado_sig = REPEAT;
                    timer_sig  = TMR_W'(REPEAT_PERIOD - 1);
                end else begin
                    timer_sig  = timer - 1'b1;
                end
            end
            default: begin
                estado_sig = IDLE;
                timer_sig  = '0;
            end
        endcase
    end

    always_comb begin
        pulso = 1'b0;
        unique case (estado)
            IDLE:         pulso = estable;
            HOLD, REPEAT: pulso = estable && (timer == '0);
            default:      pulso = 1'b0;
        endcase
    end
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        unique case (estado)
            IDLE:    if (estable)  estado_sig = HOLD;
            HOLD:    if (!estable) estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    always_comb begin
        pulso = 1'b0;
        if (estado == IDLE) begin
            pulso = estable;
        end
    end
`endif

endmodule

// File: rtl/acondicionador_botones.sv
// ---------------------------------------------------------------------------
// acondicionador_botones
//   Turns the two raw frequency buttons into clean one-cycle increase /
//   decrease commands. Each channel is conditioned by canal_boton; this
//   level masks a channel while the other button is held and registers
//   the resulting pulses. Hold-to-repeat is enabled by AUTO_REPEAT_EN.
//
//   Ports:
//     CLK_100MHz      system clock
//     reset           synchronous, active-low reset
//     btn_aumentar    raw "increase" button (active-high)
//     btn_disminuir   raw "decrease" button (active-high)
//     aumentar_Frec   registered one-cycle increase pulse
//     disminuir_Frec  registered one-cycle decrease pulse
//     btn_estable     debounced levels {disminuir, aumentar}
// ---------------------------------------------------------------------------
module acondicionador_botones
    import botones_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic       CLK_100MHz,
    input  logic       reset,
    input  logic       btn_aumentar,
    input  logic       btn_disminuir,
    output logic       aumentar_Frec,
    output logic       disminuir_Frec,
    output logic [1:0] btn_estable
);

    logic pulso_aum;
    logic pulso_dis;
    logic estable_aum;
    logic estable_dis;

    canal_boton #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_aumentar (
        .clk     (CLK_100MHz),
        .reset   (reset),
        .btn     (btn_aumentar),
        .pulso   (pulso_aum),
        .estable (estable_aum)
    );

    canal_boton #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_disminuir (
        .clk     (CLK_100MHz),
        .reset   (reset),
        .btn     (btn_disminuir),
        .pulso   (pulso_dis),
        .estable (estable_dis)
    );

    assign btn_estable = {estable_dis, estable_aum};

    // A channel request implies its own stable level is high, so masking
    // with the other stable level keeps the two outputs mutually exclusive.
    // Masked channels keep their FSMs running to preserve the repeat cadence.
    always_ff @(posedge CLK_100MHz) begin
        if (!reset) begin
            aumentar_Frec  <= 1'b0;
            disminuir_Frec <= 1'b0;
        end else begin
            aumentar_Frec  <= pulso_aum & ~estable_dis;
            disminuir_Frec <= pulso_dis & ~estable_aum;
        end
    end

endmodule

// File: tb/tb_acondicionador_botones.sv
// ---------------------------------------------------------------------------
// tb_acondicionador_botones
//   Directed bench with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
//   Edges inside a window are numbered from 1 (first edge sampling the new
//   inputs); bit n of reg_a/reg_d holds the output seen after edge n.
// ---------------------------------------------------------------------------
module tb_acondicionador_botones;

    logic       CLK_100MHz;
    logic       reset;
    logic       btn_aumentar;
    logic       btn_disminuir;
    logic       aumentar_Frec;
    logic       disminuir_Frec;
    logic [1:0] btn_estable;

    acondicionador_botones #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .CLK_100MHz     (CLK_100MHz),
        .reset          (reset),
        .btn_aumentar   (btn_aumentar),
        .btn_disminuir  (btn_disminuir),
        .aumentar_Frec  (aumentar_Frec),
        .disminuir_Frec (disminuir_Frec),
        .btn_estable    (btn_estable)
    );

    initial CLK_100MHz = 1'b0;
    always #5 CLK_100MHz = ~CLK_100MHz;

    int unsigned   n_asserts = 0;
    int unsigned   n_fallos  = 0;
    int unsigned   n_solapes = 0;
    int unsigned   idx       = 0;
    logic [127:0]  reg_a;
    logic [127:0]  reg_d;
    logic [127:0]  esp;

    task automatic verificar(input string etiqueta, input logic [127:0] obtenido,
                             input logic [127:0] esperado);
        n_asserts++;
        if (obtenido !== esperado) begin
            n_fallos++;
            $display("FAIL %s: got %0h expected %0h", etiqueta, obtenido, esperado);
        end
    endtask

    task automatic nueva_ventana();
        idx   = 0;
        reg_a = '0;
        reg_d = '0;
    endtask

    task automatic paso(input logic rst_n, input logic a, input logic d);
        reset         = rst_n;
        btn_aumentar  = a;
        btn_disminuir = d;
        @(posedge CLK_100MHz);
        #1;
        idx++;
        if (idx < 128) begin
            reg_a[idx] = aumentar_Frec;
            reg_d[idx] = disminuir_Frec;
        end
        if (aumentar_Frec && disminuir_Frec) n_solapes++;
    endtask

    initial begin
        reset         = 1'b0;
        btn_aumentar  = 1'b0;
        btn_disminuir = 1'b0;

        // Reset state
        nueva_ventana();
        repeat (3) paso(1'b0, 1'b0, 1'b0);
        verificar("reset_aumentar", 128'(aumentar_Frec), 128'd0);
        verificar("reset_disminuir", 128'(disminuir_Frec), 128'd0);
        verificar("reset_estable", 128'(btn_estable), 128'd0);
        repeat (4) paso(1'b1, 1'b0, 1'b0);

        // Clean press: single pulse on edge 7
        nueva_ventana();
        repeat (10) paso(1'b1, 1'b1, 1'b0);
        esp = '0; esp[7] = 1'b1;
        verificar("clean_aumentar", reg_a, esp);
        verificar("clean_disminuir", reg_d, 128'd0);
        verificar("clean_estable", 128'(btn_estable), 128'd1);

        // Release latency: stable drops on the 6th edge, no pulse
        nueva_ventana();
        repeat (5) paso(1'b1, 1'b0, 1'b0);
        verificar("release_edge5", 128'(btn_estable), 128'd1);
        paso(1'b1, 1'b0, 1'b0);
        verificar("release_edge6", 128'(btn_estable), 128'd0);
        repeat (4) paso(1'b1, 1'b0, 1'b0);
        verificar("release_no_pulse", reg_a | reg_d, 128'd0);

        // Short glitch (3 cycles) is discarded
        nueva_ventana();
        repeat (3)  paso(1'b1, 1'b1, 1'b0);
        repeat (10) paso(1'b1, 1'b0, 1'b0);
        verificar("glitch_no_pulse", reg_a | reg_d, 128'd0);
        verificar("glitch_estable", 128'(btn_estable), 128'd0);

        // Bounce on disminuir: high 3, low 2, then held -> one pulse on edge 12
        nueva_ventana();
        repeat (3)  paso(1'b1, 1'b0, 1'b1);
        repeat (2)  paso(1'b1, 1'b0, 1'b0);
        repeat (11) paso(1'b1, 1'b0, 1'b1);
        esp = '0; esp[12] = 1'b1;
        verificar("bounce_disminuir", reg_d, esp);
        verificar("bounce_aumentar", reg_a, 128'd0);
        verificar("bounce_estable", 128'(btn_estable), 128'd2);
        nueva_ventana();
        repeat (12) paso(1'b1, 1'b0, 1'b0);
        verificar("bounce_release", reg_a | reg_d, 128'd0);
        verificar("bounce_release_estable", 128'(btn_estable), 128'd0);

        // Auto-repeat: hold aumentar 60 edges
        nueva_ventana();
        repeat (60) paso(1'b1, 1'b1, 1'b0);
        esp = '0; esp[7] = 1'b1;
`ifdef AUTO_REPEAT_EN
        esp[27] = 1'b1; esp[35] = 1'b1; esp[43] = 1'b1; esp[51] = 1'b1; esp[59] = 1'b1;
`endif
        verificar("repeat_aumentar", reg_a, esp);
        verificar("repeat_disminuir", reg_d, 128'd0);
        nueva_ventana();
        repeat (12) paso(1'b1, 1'b0, 1'b0);
        verificar("repeat_release", reg_a | reg_d, 128'd0);

        // Simultaneous press: both masked; release disminuir after 30 edges
        nueva_ventana();
        repeat (30) paso(1'b1, 1'b1, 1'b1);
        verificar("simul_aumentar", reg_a, 128'd0);
        verificar("simul_disminuir", reg_d, 128'd0);
        verificar("simul_estable", 128'(btn_estable), 128'd3);
        repeat (30) paso(1'b1, 1'b1, 1'b0);
        esp = '0;
`ifdef AUTO_REPEAT_EN
        esp[43] = 1'b1; esp[51] = 1'b1; esp[59] = 1'b1;
`endif
        verificar("simul_resume_aumentar", reg_a, esp);
        verificar("simul_resume_disminuir", reg_d, 128'd0);
        nueva_ventana();
        repeat (12) paso(1'b1, 1'b0, 1'b0);
        verificar("simul_release", reg_a | reg_d, 128'd0);

        // Reset mid-hold: edges 41-42 in reset, fresh pulse on edge 49
        nueva_ventana();
        repeat (40) paso(1'b1, 1'b1, 1'b0);
        repeat (2)  paso(1'b0, 1'b1, 1'b0);
        verificar("rst_mid_aumentar", 128'(aumentar_Frec), 128'd0);
        verificar("rst_mid_disminuir", 128'(disminuir_Frec), 128'd0);
        verificar("rst_mid_estable", 128'(btn_estable), 128'd0);
        repeat (20) paso(1'b1, 1'b1, 1'b0);
        esp = '0; esp[7] = 1'b1; esp[49] = 1'b1;
`ifdef AUTO_REPEAT_EN
        esp[27] = 1'b1; esp[35] = 1'b1;
`endif
        verificar("rst_mid_pulses", reg_a, esp);
        verificar("rst_mid_pulses_dis", reg_d, 128'd0);
        nueva_ventana();
        repeat (12) paso(1'b1, 1'b0, 1'b0);
        verificar("final_release", reg_a | reg_d, 128'd0);

        verificar("no_overlap", 128'(n_solapes), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fallos);
        $finish;
    end

endmodule
